pixel_normalizer_mc: RTL
========================

Name: pixel_normalizer_mc

Overview:
Parametrised, multi-channel successor to the single-channel pixel normalizer. Takes a channel-interleaved pixel stream (e.g. R,G,B,R,G,B…), applies per-channel (pixel − mean) × scale in fixed point with rounding and saturation, and emits signed Qm.FRAC_BITS samples to the CNN input buffer. Fully pipelined with valid/ready backpressure; coefficients are runtime-programmable.

Parameters:
PIX_W, 8, unsigned input pixel width
OUT_W, 16, signed output width
FRAC_BITS, 8, fractional bits of mean, scale and output
COEF_W, 16, signed scale width (Q(COEF_W−FRAC_BITS).FRAC_BITS)
NUM_CH, 3, channels per pixel group (≥1)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
valid_in  in  1  input beat valid
ready_in  out  1  block can accept a beat
sof_in  in  1  first beat of frame; forces this beat to channel 0
pixel_in  in  PIX_W  unsigned pixel
valid_out  out  1  output beat valid
ready_out  in  1  downstream accepts
pixel_out  out  OUT_W  signed normalized sample
ch_out  out  clog2(NUM_CH) (min 1)  channel of pixel_out
last_ch_out  out  1  ch_out == NUM_CH−1
sat_out  out  1  pixel_out was clipped
cfg_we  in  1  coefficient write strobe
cfg_sel  in  1  0 = mean, 1 = scale
cfg_ch  in  clog2(NUM_CH) (min 1)  target channel
cfg_data  in  COEF_W  mean (unsigned, PIX_W+FRAC_BITS LSBs used) or scale (signed)

Behaviour:
- Reset (rst=1 at clk edge): valid_out, pixel_out, ch_out, last_ch_out, sat_out = 0; all pipeline valids 0; channel counter 0; mean[c]=0, scale[c]=1<<FRAC_BITS (identity: out = pixel<<FRAC_BITS). Reset mid-stream drops all in-flight beats.
- Handshake: advance = ~valid_out | ready_out; ready_in = advance (combinational). Beat accepted when valid_in & ready_in. When advance=0 all stages hold; pixel_out/ch_out stable while valid_out & ~ready_out. Bubbles propagate as valid=0.
- Latency: 3 cycles accept-to-valid_out with no stall; throughput 1 beat/cycle.
- Channel counter: accepted beat tagged ch = sof_in ? 0 : cnt; cnt_next = (ch == NUM_CH−1) ? 0 : ch+1. Only changes on accept. NUM_CH=1: ch always 0, last_ch_out always 1 when valid.
- Stage 1: register pixel, ch, mean[ch], scale[ch] (coefficients sampled at accept).
- Stage 2: diff = (pixel<<FRAC_BITS) − mean, signed PIX_W+FRAC_BITS+1 bits; prod = diff × scale, full width, signed.
- Stage 3: r = (prod + 2^(FRAC_BITS−1)) >>> FRAC_BITS (round half up, arithmetic shift); saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; sat_out=1 iff clipped.
- Config: cfg_we at edge N updates mean/scale[cfg_ch]; beats accepted at edge N+1 onward use new value; beats already in flight keep old value. cfg_ch ≥ NUM_CH ignored. Same-cycle cfg write and accept on same channel: accepted beat uses OLD value. Config ignored during rst.
- No internal FIFO; no data loss under any ready_out pattern.

Test Plan:
- Identity after reset: channel-0 stream 0,64,127,192,255 -> pixel_out 0x0000,0x4000,0x7F00,0xC000(clip? no: 0xC000 in range? 192·256=49152 > 32767 -> 0x7FFF sat_out=1),0x7FFF sat_out=1; 0 and 64 and 127 unsaturated, sat_out=0, each valid_out exactly 3 cycles after accept.
- Mean/scale: mean[1]=128<<8, scale[1]=0x0080 (0.5); pixel 255 on ch1 -> (127·256)·0.5 = 0x3F80; pixel 0 -> 0xC000 (−16384), sat_out=0.
- Rounding/negative sat: scale[0]=0x7FFF, mean[0]=255<<8, pixel 0 -> clips to 0x8000, sat_out=1; scale 0x0001, pixel 1 -> 1·256·1=256, +128 >>8 -> 0x0001.
- Channel sequencing: NUM_CH=3, 7 beats with sof_in on beat 0 and beat 4 -> ch_out 0,1,2,0,0,1,2; last_ch_out on beats 2 and 6.
- Backpressure: random ready_out (50%) over 1000 beats, random valid_in -> output sequence equals reference model, no drops/duplicates, pixel_out stable while stalled, ready_in low exactly when valid_out & ~ready_out.
- Mid-stream reset and cfg race: rst for 1 cycle with 3 beats in flight -> valid_out 0 next cycle, next accepted beat ch 0, coefficients back to identity; cfg write on accept cycle -> that beat uses old coefficient, next beat new.

Source files
------------

// File: rtl/pixel_normalizer_mc.sv
// Per-channel fixed-point pixel normalizer: out = sat(round((pixel - mean[ch]) * scale[ch])).
// Latency: 3 cycles from input beat to valid_out; 1 beat/cycle throughput.
// Backpressure: one global advance (~valid_out | ready_out) holds every stage, so ready_in drops only while the output is stalled.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   valid_in/ready_in/sof_in      input handshake; sof_in pins the beat to channel 0
//   pixel_in                      unsigned pixel, channel-interleaved
//   valid_out/ready_out           output handshake
//   pixel_out/ch_out              signed Q(OUT_W-FRAC_BITS).FRAC_BITS sample and its channel
//   last_ch_out/sat_out           last channel of the group / sample was clipped
//   cfg_we/cfg_sel/cfg_ch/cfg_data  coefficient write port (sel 0 = mean, 1 = scale)
module pixel_normalizer_mc #(
    parameter int PIX_W     = 8,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 8,
    parameter int COEF_W    = 16,
    parameter int NUM_CH    = 3,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              sof_in,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [OUT_W-1:0]  pixel_out,
    output logic [CH_W-1:0]   ch_out,
    output logic              last_ch_out,
    output logic              sat_out,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [COEF_W-1:0] cfg_data
);

    localparam int MEAN_W = PIX_W + FRAC_BITS;
    localparam int DIFF_W = MEAN_W + 1;
    localparam int PROD_W = DIFF_W + COEF_W;

    localparam logic signed [PROD_W-1:0] RND    = PROD_W'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [PROD_W-1:0] SAT_HI = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_LO = ~SAT_HI;

    // Coefficient storage
    logic [MEAN_W-1:0]        mean_q  [NUM_CH];
    logic signed [COEF_W-1:0] scale_q [NUM_CH];

    // Channel tracking and input-side selection
    logic [CH_W-1:0]          cnt_q;
    logic [CH_W-1:0]          in_ch;
    logic [CH_W-1:0]          cnt_nxt;
    logic                     in_last;
    logic [MEAN_W-1:0]        in_mean;
    logic signed [COEF_W-1:0] in_scale;

    logic advance;
    logic accept;

    // Stage 1
    logic                     s1_vld;
    logic [PIX_W-1:0]         s1_pix;
    logic [CH_W-1:0]          s1_ch;
    logic [MEAN_W-1:0]        s1_mean;
    logic signed [COEF_W-1:0] s1_scale;

    // Stage 2
    logic                     s2_vld;
    logic signed [PROD_W-1:0] s2_prod;
    logic [CH_W-1:0]          s2_ch;

    logic signed [DIFF_W-1:0] diff_c;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] scale_ext;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] rnd_c;
    logic signed [PROD_W-1:0] shr_c;
    logic                     clip_hi;
    logic                     clip_lo;
    logic [OUT_W-1:0]         res_c;

    assign advance  = ~valid_out | ready_out;
    assign ready_in = advance;
    assign accept   = valid_in & advance;

    always_comb begin
        in_ch    = sof_in ? '0 : cnt_q;
        in_last  = (in_ch == CH_W'(NUM_CH - 1));
        cnt_nxt  = in_last ? '0 : in_ch + CH_W'(1);
        in_mean  = '0;
        in_scale = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
                in_mean  = mean_q[c];
                in_scale = scale_q[c];
            end
        end
    end

    // A write landing on the same edge as an accept is not seen by that beat:
    // stage 1 samples the pre-edge array contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mean_q[c]  <= '0;
                scale_q[c] <= COEF_W'(1 << FRAC_BITS);
            end
        end else if (cfg_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_ch == CH_W'(c)) begin
                    if (cfg_sel) begin
                        scale_q[c] <= cfg_data;
                    end else begin
                        mean_q[c] <= MEAN_W'(cfg_data);
                    end
                end
            end
        end
    end

    // Stage 2 arithmetic: product fits PROD_W exactly, so no truncation here.
    always_comb begin
        diff_c    = $signed({1'b0, s1_pix, {FRAC_BITS{1'b0}}}) - $signed({1'b0, s1_mean});
        diff_ext  = {{(PROD_W-DIFF_W){diff_c[DIFF_W-1]}}, diff_c};
        scale_ext = {{(PROD_W-COEF_W){s1_scale[COEF_W-1]}}, s1_scale};
        prod_c    = diff_ext * scale_ext;
    end

    // Stage 3 arithmetic: round half up, then clip to the output range.
    always_comb begin
        rnd_c   = s2_prod + RND;
        shr_c   = rnd_c >>> FRAC_BITS;
        clip_hi = (shr_c > SAT_HI);
        clip_lo = (shr_c < SAT_LO);
        if (clip_hi) begin
            res_c = SAT_HI[OUT_W-1:0];
        end else if (clip_lo) begin
            res_c = SAT_LO[OUT_W-1:0];
        end else begin
            res_c = shr_c[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            s1_vld      <= 1'b0;
            s1_pix      <= '0;
            s1_ch       <= '0;
            s1_mean     <= '0;
            s1_scale    <= '0;
            s2_vld      <= 1'b0;
            s2_prod     <= '0;
            s2_ch       <= '0;
            valid_out   <= 1'b0;
            pixel_out   <= '0;
            ch_out      <= '0;
            last_ch_out <= 1'b0;
            sat_out     <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                cnt_q <= cnt_nxt;
            end
            s1_vld      <= valid_in;
            s1_pix      <= pixel_in;
            s1_ch       <= in_ch;
            s1_mean     <= in_mean;
            s1_scale    <= in_scale;
            s2_vld      <= s1_vld;
            s2_prod     <= prod_c;
            s2_ch       <= s1_ch;
            valid_out   <= s2_vld;
            pixel_out   <= res_c;
            ch_out      <= s2_ch;
            last_ch_out <= (s2_ch == CH_W'(NUM_CH - 1));
            sat_out     <= clip_hi | clip_lo;
        end
    end

endmodule
